// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Drains bytes from the read side of the async byte FIFO and packs them
// little-endian into BYTES_PER_WORD-byte words on a valid/ready output.
// A partial word is flushed once the FIFO has stayed idle for
// FLUSH_TIMEOUT cycles, so trailing bytes never get stranded.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_TIMEOUT  = 16
) (
  input  logic                              RCLK,
  input  logic                              RST,
  input  logic                              EMPTY,
  output logic                              READ_ENABLE,
  input  logic [7:0]                        READ_DATA,
  output logic [8*BYTES_PER_WORD-1:0]       WORD_OUT,
  output logic [$clog2(BYTES_PER_WORD):0]   WORD_BYTES,
  output logic                              WORD_VALID,
  input  logic                              WORD_READY,
  output logic [15:0]                       WORD_COUNT
);

  localparam int CW = $clog2(BYTES_PER_WORD) + 1;
  localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(BYTES_PER_WORD);
  localparam logic [CW:0]   WORD_LIMIT = (CW+1)'(BYTES_PER_WORD);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(FLUSH_TIMEOUT);
  localparam bit            FLUSH_EN   = (FLUSH_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ACC_EMPTY,
    ACC_PARTIAL,
    ACC_FULL
  } acc_state_t;

  logic [8*BYTES_PER_WORD-1:0] acc;
  logic [8*BYTES_PER_WORD-1:0] acc_masked;
  logic [CW-1:0]               acc_cnt;
  logic [CW-1:0]               base;
  logic [CW:0]                 demand;
  logic [TW-1:0]               idle_cnt;
  logic                        inflight;
  acc_state_t                  acc_state;
  logic                        slot_free;
  logic                        full_xfer;
  logic                        flush_xfer;
  logic                        xfer;
  logic                        idle_step;

  // Classify the accumulator fill level from its byte count
  always_comb begin
    acc_state = ACC_PARTIAL;
    if (acc_cnt == '0) begin
      acc_state = ACC_EMPTY;
    end else if (acc_cnt == FULL_CNT) begin
      acc_state = ACC_FULL;
    end
  end

  // Decide whether the accumulator moves to the output register this cycle
  always_comb begin
    slot_free  = !WORD_VALID || WORD_READY;
    full_xfer  = (acc_state == ACC_FULL) && slot_free;
    flush_xfer = FLUSH_EN && (acc_state == ACC_PARTIAL) &&
                 (idle_cnt == IDLE_LIMIT) && slot_free;
    xfer       = full_xfer || flush_xfer;
    idle_step  = (acc_state == ACC_PARTIAL) && !inflight && EMPTY;
  end

  // Issue a pop only if the byte (plus any in flight) still fits in the word being built
  always_comb begin
    base        = xfer ? '0 : acc_cnt;
    demand      = {1'b0, base} + {{CW{1'b0}}, inflight};
    READ_ENABLE = RST && !EMPTY && (demand < WORD_LIMIT);
  end

  // Zero the lanes above the fill level so a flushed partial word is clean
  always_comb begin
    acc_masked = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (CW'(i) < acc_cnt) begin
        acc_masked[8*i +: 8] = acc[8*i +: 8];
      end
    end
  end

  // Accumulator and output register; capture never coincides with a transfer
  always_ff @(posedge RCLK) begin
    if (!RST) begin
      acc        <= '0;
      acc_cnt    <= '0;
      inflight   <= 1'b0;
      WORD_OUT   <= '0;
      WORD_BYTES <= '0;
      WORD_VALID <= 1'b0;
    end else begin
      inflight <= READ_ENABLE;
      if (xfer) begin
        WORD_OUT   <= acc_masked;
        WORD_BYTES <= acc_cnt;
        WORD_VALID <= 1'b1;
        acc        <= '0;
        acc_cnt    <= '0;
      end else begin
        if (WORD_READY) begin
          WORD_VALID <= 1'b0;
        end
        if (inflight) begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (acc_cnt == CW'(i)) begin
              acc[8*i +: 8] <= READ_DATA;
            end
          end
          acc_cnt <= acc_cnt + 1'b1;
        end
      end
    end
  end

  // Count consecutive idle cycles of a partial word, saturating at the timeout
  always_ff @(posedge RCLK) begin
    if (!RST) begin
      idle_cnt <= '0;
    end else if (idle_step && !xfer) begin
      if (idle_cnt != IDLE_LIMIT) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  // Count accepted words, wrapping naturally at 16 bits
  always_ff @(posedge RCLK) begin
    if (!RST) begin
      WORD_COUNT <= '0;
    end else if (WORD_VALID && WORD_READY) begin
      WORD_COUNT <= WORD_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
// Directed and randomized bench for fifo_word_packer. A queue-based FIFO
// feeds the packer; expected words come from grouping the written bytes.
module tb_fifo_word_packer;

  localparam int BPW      = 4;
  localparam int NUM_RAND = 40;

  logic        rclk = 1'b0;
  logic        rst;
  logic        empty = 1'b1;
  logic        read_enable;
  logic [7:0]  read_data = 8'h00;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word_count;

  logic        empty_nf = 1'b1;
  logic        read_enable_nf;
  logic [7:0]  read_data_nf = 8'h00;
  logic [31:0] word_out_nf;
  logic [2:0]  word_bytes_nf;
  logic        word_valid_nf;
  logic [15:0] word_count_nf;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pending[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  pending_nf[$];
  logic [7:0]  fifo_nf[$];
  logic [7:0]  data_q[$];
  logic [31:0] got_w[$];
  logic [2:0]  got_b[$];
  logic [31:0] exp_w[$];
  logic [2:0]  exp_b[$];

  bit          hold_empty = 1'b0;
  int          cyc = 0;
  int          pops = 0;
  int          pops_base = 0;
  int          last_pop_cyc = 0;
  int          rise_cyc = 0;
  int          underflows = 0;
  int          underflows_nf = 0;
  int          guard_viol = 0;
  int          stab_viol = 0;
  int          nf_valid_seen = 0;
  bit          prev_valid = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_out = '0;
  logic [2:0]  prev_bytes = '0;
  int          k;
  int          nbytes;
  int          mism;
  int          lane_bad;
  logic [7:0]  lane;

  fifo_word_packer #(.BYTES_PER_WORD(4), .FLUSH_TIMEOUT(16)) dut (
    .RCLK(rclk), .RST(rst), .EMPTY(empty), .READ_ENABLE(read_enable),
    .READ_DATA(read_data), .WORD_OUT(word_out), .WORD_BYTES(word_bytes),
    .WORD_VALID(word_valid), .WORD_READY(word_ready), .WORD_COUNT(word_count)
  );

  fifo_word_packer #(.BYTES_PER_WORD(4), .FLUSH_TIMEOUT(0)) dut_nf (
    .RCLK(rclk), .RST(rst), .EMPTY(empty_nf), .READ_ENABLE(read_enable_nf),
    .READ_DATA(read_data_nf), .WORD_OUT(word_out_nf), .WORD_BYTES(word_bytes_nf),
    .WORD_VALID(word_valid_nf), .WORD_READY(1'b1), .WORD_COUNT(word_count_nf)
  );

  always #5 rclk = ~rclk;

  // FIFO model for the main packer: pop on sampled read enable, registered empty flag
  always @(posedge rclk) begin
    cyc++;
    if (read_enable) begin
      pops++;
      last_pop_cyc = cyc;
      if (fifo_q.size() == 0) underflows++;
      else read_data <= fifo_q.pop_front();
    end
    while (pending.size() > 0) fifo_q.push_back(pending.pop_front());
    empty <= (fifo_q.size() == 0) || hold_empty;
  end

  // FIFO model for the flush-disabled packer
  always @(posedge rclk) begin
    if (read_enable_nf) begin
      if (fifo_nf.size() == 0) underflows_nf++;
      else read_data_nf <= fifo_nf.pop_front();
    end
    while (pending_nf.size() > 0) fifo_nf.push_back(pending_nf.pop_front());
    empty_nf <= (fifo_nf.size() == 0);
  end

  // Monitor: record accepted words, watch the empty guard and output stability
  always @(negedge rclk) begin
    if (read_enable && empty) guard_viol++;
    if (word_valid_nf) nf_valid_seen++;
    if (prev_hold && (word_valid !== 1'b1 || word_out !== prev_out || word_bytes !== prev_bytes))
      stab_viol++;
    prev_hold  = word_valid && !word_ready && rst;
    prev_out   = word_out;
    prev_bytes = word_bytes;
    if (word_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = word_valid;
    if (word_valid && word_ready && rst) begin
      got_w.push_back(word_out);
      got_b.push_back(word_bytes);
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge rclk);
      #2;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushBytes(input logic [7:0] b[$]);
    foreach (b[i]) pending.push_back(b[i]);
  endtask

  // Reference: group bytes little-endian, the remainder becomes a flushed partial word
  task automatic buildExpected(input logic [7:0] b[$]);
    exp_w.delete();
    exp_b.delete();
    for (int i = 0; i < b.size(); i += BPW) begin
      logic [31:0] w;
      int n;
      w = '0;
      n = 0;
      for (int j = 0; j < BPW; j++) begin
        if (i + j < b.size()) begin
          w = w | (32'(b[i+j]) << (8 * j));
          n++;
        end
      end
      exp_w.push_back(w);
      exp_b.push_back(3'(n));
    end
  endtask

  task automatic waitWords(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (got_w.size() < n && c < budget) begin
      @(negedge rclk);
      c++;
    end
    checkOutput({tag, "_timeout"}, 64'(got_w.size() >= n), 64'd1);
  endtask

  task automatic compareWords(input string tag);
    checkOutput({tag, "_nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checkOutput({tag, "_word"}, 64'(got_w[i]), 64'(exp_w[i]));
      checkOutput({tag, "_bytes"}, 64'(got_b[i]), 64'(exp_b[i]));
    end
  endtask

  function automatic int gotBytes();
    int s;
    s = 0;
    foreach (got_b[i]) s += int'(got_b[i]);
    return s;
  endfunction

  // Overall time limit so the run always reaches a summary line
  initial begin
    #900000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of tests
  initial begin
    rst = 1'b0;
    word_ready = 1'b0;
    applyStimulus(2);
    checkOutput("rst_valid", 64'(word_valid), 64'd0);
    checkOutput("rst_out", 64'(word_out), 64'd0);
    checkOutput("rst_bytes", 64'(word_bytes), 64'd0);
    checkOutput("rst_count", 64'(word_count), 64'd0);
    checkOutput("rst_re", 64'(read_enable), 64'd0);
    rst = 1'b1;

    $display("[TB] basic packing");
    data_q.delete();
    for (int i = 1; i <= 15; i++) data_q.push_back(8'(i * 17));
    word_ready = 1'b1;
    got_w.delete(); got_b.delete();
    pushBytes(data_q);
    buildExpected(data_q);
    waitWords("basic", 4, 200);
    applyStimulus(1);
    compareWords("basic");
    checkOutput("basic_flush_lat", 64'(rise_cyc - last_pop_cyc), 64'd18);
    checkOutput("basic_count", 64'(word_count), 64'd4);

    $display("[TB] backpressure");
    got_w.delete(); got_b.delete();
    word_ready = 1'b0;
    pops_base = pops;
    pushBytes(data_q);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1);
      if (word_valid) checkOutput("bp_hold", 64'(word_out), 64'h44332211);
    end
    checkOutput("bp_pops", 64'(pops - pops_base), 64'd8);
    checkOutput("bp_valid", 64'(word_valid), 64'd1);
    word_ready = 1'b1;
    waitWords("bp", 4, 200);
    applyStimulus(1);
    compareWords("bp");
    checkOutput("bp_count", 64'(word_count), 64'd8);
    checkOutput("bp_stable", 64'(stab_viol), 64'd0);

    $display("[TB] flush cancel");
    got_w.delete(); got_b.delete();
    data_q = '{8'hA1, 8'hA2};
    pushBytes(data_q);
    applyStimulus(10);
    data_q = '{8'hA3, 8'hA4};
    pushBytes(data_q);
    applyStimulus(40);
    data_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    buildExpected(data_q);
    compareWords("cancel");
    checkOutput("cancel_count", 64'(word_count), 64'd9);

    $display("[TB] flush disabled");
    nf_valid_seen = 0;
    for (int i = 0; i < 3; i++) pending_nf.push_back(8'($urandom));
    applyStimulus(200);
    checkOutput("nf_valid_seen", 64'(nf_valid_seen), 64'd0);
    checkOutput("nf_acc_cnt", 64'(dut_nf.acc_cnt), 64'd3);
    checkOutput("nf_count", 64'(word_count_nf), 64'd0);
    checkOutput("nf_out", 64'(word_out_nf), 64'd0);
    checkOutput("nf_bytes", 64'(word_bytes_nf), 64'd0);
    checkOutput("nf_underflow", 64'(underflows_nf), 64'd0);

    $display("[TB] reset mid-word");
    data_q.delete();
    for (int i = 0; i < 6; i++) data_q.push_back(8'($urandom));
    pops_base = pops;
    pushBytes(data_q);
    k = 0;
    while (pops - pops_base < 5 && k < 100) begin
      @(negedge rclk);
      k++;
    end
    checkOutput("rm_reach", 64'(pops - pops_base >= 5), 64'd1);
    @(posedge rclk);
    #2 rst = 1'b0;
    @(posedge rclk);
    #1;
    checkOutput("rm_valid", 64'(word_valid), 64'd0);
    checkOutput("rm_out", 64'(word_out), 64'd0);
    checkOutput("rm_bytes", 64'(word_bytes), 64'd0);
    checkOutput("rm_count", 64'(word_count), 64'd0);
    checkOutput("rm_re", 64'(read_enable), 64'd0);
    #1 rst = 1'b1;
    got_w.delete(); got_b.delete();
    data_q.delete();
    for (int i = 0; i < 4; i++) data_q.push_back(8'($urandom));
    pushBytes(data_q);
    buildExpected(data_q);
    waitWords("rm_post", 1, 100);
    applyStimulus(1);
    compareWords("rm_post");
    checkOutput("rm_post_count", 64'(word_count), 64'd1);

    $display("[TB] random stream with empty toggling");
    got_w.delete(); got_b.delete();
    data_q.delete();
    for (int i = 0; i < NUM_RAND; i++) data_q.push_back(8'($urandom));
    pushBytes(data_q);
    k = 0;
    while (gotBytes() < NUM_RAND && k < 4000) begin
      hold_empty = 1'($urandom_range(0, 1));
      word_ready = 1'($urandom_range(0, 1));
      applyStimulus(1);
      k++;
    end
    hold_empty = 1'b0;
    word_ready = 1'b1;
    applyStimulus(2);
    checkOutput("rand_timeout", 64'(gotBytes() >= NUM_RAND), 64'd1);
    nbytes = 0;
    mism = 0;
    lane_bad = 0;
    foreach (got_w[i]) begin
      if (got_b[i] < 3'd1 || got_b[i] > 3'd4) lane_bad++;
      for (int j = 0; j < BPW; j++) begin
        lane = 8'(got_w[i] >> (8 * j));
        if (j < int'(got_b[i])) begin
          if (nbytes >= NUM_RAND || lane !== data_q[nbytes]) mism++;
          nbytes++;
        end else if (lane !== 8'h00) begin
          lane_bad++;
        end
      end
    end
    checkOutput("rand_nbytes", 64'(nbytes), 64'(NUM_RAND));
    checkOutput("rand_stream", 64'(mism), 64'd0);
    checkOutput("rand_lanes", 64'(lane_bad), 64'd0);
    checkOutput("rand_count", 64'(word_count), 64'(16'(1 + got_w.size())));
    checkOutput("rand_guard", 64'(guard_viol), 64'd0);
    checkOutput("rand_underflow", 64'(underflows), 64'd0);
    checkOutput("rand_stable", 64'(stab_viol), 64'd0);

    $display("[TB] word count wrap");
    applyStimulus(3);
    force dut.WORD_COUNT = 16'hFFFF;
    applyStimulus(1);
    release dut.WORD_COUNT;
    got_w.delete(); got_b.delete();
    data_q.delete();
    for (int i = 0; i < 4; i++) data_q.push_back(8'($urandom));
    pushBytes(data_q);
    buildExpected(data_q);
    waitWords("wrap", 1, 100);
    applyStimulus(1);
    compareWords("wrap");
    checkOutput("wrap_count", 64'(word_count), 64'd0);
    checkOutput("final_guard", 64'(guard_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer of the asynchronous byte FIFO, running entirely in the read clock domain. Drains 8-bit entries through the FIFO's read-enable/empty interface and packs them little-endian into BYTES_PER_WORD-byte words on a valid/ready output. A partial word is flushed after a programmable idle timeout, so trailing bytes are never stranded.

## Interface
- BYTES_PER_WORD, 4: bytes per output word; must be at least 2.
- FLUSH_TIMEOUT, 16: idle cycles before a partial word is flushed; 0 disables flushing.
- RCLK  in  1  read-domain clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset; one clock, and reset is synchronous and active-low.
- EMPTY  in  1  FIFO empty flag, synchronous to RCLK.
- READ_ENABLE  out  1  FIFO read request; one entry is popped per cycle it is sampled high.
- READ_DATA  in  8  FIFO read data, valid the cycle after READ_ENABLE is sampled high.
- WORD_OUT  out  8*BYTES_PER_WORD  packed word; the first byte read sits in [7:0].
- WORD_BYTES  out  clog2(BYTES_PER_WORD)+1  number of valid bytes in WORD_OUT (1..BYTES_PER_WORD).
- WORD_VALID  out  1  output word available.
- WORD_READY  in  1  downstream accepts the word when it is high together with WORD_VALID.
- WORD_COUNT  out  16  number of accepted words; wraps 0xFFFF->0x0000.

## Operation
- Internal state:
  - accumulator ACC with count acc_cnt (0..BYTES_PER_WORD);
  - inflight flag (a read was issued last cycle);
  - idle counter;
  - output register holding WORD_OUT, WORD_BYTES and WORD_VALID.
- Accumulator states:
  - ACC_EMPTY: acc_cnt=0.
  - ACC_PARTIAL: acc_cnt is 1..BYTES_PER_WORD-1.
  - ACC_FULL: acc_cnt=BYTES_PER_WORD.
- Read issue: READ_ENABLE = EMPTY==0 && (base + inflight < BYTES_PER_WORD).
  - base = 0 if a transfer occurs this cycle, else acc_cnt.
  - READ_ENABLE is combinational from registered state and EMPTY.
- Capture: when inflight=1, READ_DATA is written to byte lane acc_cnt and acc_cnt increments.
- Out-slot free: WORD_VALID==0 || WORD_READY==1.
- Full transfer: ACC_FULL && out-slot free.
  - ACC moves to the output register with WORD_BYTES=BYTES_PER_WORD.
  - acc_cnt returns to 0.
- Flush transfer: FLUSH_TIMEOUT!=0 && ACC_PARTIAL && idle counter == FLUSH_TIMEOUT && out-slot free.
  - Moves the acc_cnt bytes; unused upper lanes are 0; WORD_BYTES=acc_cnt.
- Idle counter:
  - Increments, saturating at FLUSH_TIMEOUT, while ACC_PARTIAL && inflight=0 && EMPTY=1.
  - Clears to 0 in any other cycle, including a transfer.
  - EMPTY falling before the flush executes cancels it; filling resumes.
- Capture and transfer are never simultaneous: no read is issued while ACC_FULL unless the transfer happens in that same cycle.
- Output register:
  - WORD_VALID clears on acceptance unless a new transfer loads it in the same cycle.
  - WORD_OUT and WORD_BYTES are held stable while WORD_VALID=1 && WORD_READY=0.
- WORD_COUNT increments on every cycle with WORD_VALID && WORD_READY.
- READ_ENABLE is never high while EMPTY=1; the block never underflows the FIFO.

## Timing
- Reset (RST=0 at a rising edge):
  - READ_ENABLE=0, WORD_VALID=0, WORD_OUT=0, WORD_BYTES=0, WORD_COUNT=0.
  - acc_cnt=0, inflight=0, idle counter=0.
  - READ_ENABLE is forced 0 while RST=0.
- Reset mid-operation:
  - Accumulator and output contents are discarded.
  - A byte popped the cycle before reset is lost; the FIFO pointer has already advanced.
- Read latency: READ_ENABLE is sampled at edge t, and READ_DATA is captured at edge t+1.
- Word latency:
  - The last byte is captured at edge k.
  - The transfer occurs at edge k+1, so WORD_VALID is high from k+1 when the out-slot is free.
- Sustained throughput with WORD_READY=1 and the FIFO never empty: BYTES_PER_WORD bytes per BYTES_PER_WORD+1 cycles.
  - One stall cycle per word, while ACC_FULL awaits transfer.
- Flush: with the default parameters, WORD_VALID rises FLUSH_TIMEOUT+1 edges after the last capture when the slot is free.
- Backpressure:
  - ACC fills while the output is held; reads then stop until the slot frees.
  - Transfer is the edge after WORD_READY is sampled high.

## Test plan
- Basic packing:
  - Stimulus: write 0x11..0xFF (15 bytes) into the FIFO; WORD_READY=1; BYTES_PER_WORD=4; FLUSH_TIMEOUT=16.
  - Required: words 0x44332211, 0x88776655, 0xCCBBAA99 with WORD_BYTES=4.
  - Then 0x00FFEEDD with WORD_BYTES=3, arriving 17 cycles after the last capture.
  - WORD_COUNT=4 at the end.
- Backpressure:
  - Stimulus: the same 15 bytes with WORD_READY=0 for 40 cycles, then 1.
  - Required: WORD_OUT holds 0x44332211 for all 40 cycles.
  - READ_ENABLE stops after exactly 8 bytes are popped.
  - Word order is unchanged after release; no byte is lost or duplicated.
- Flush cancel:
  - Stimulus: write 2 bytes (0xA1, 0xA2), wait 10 cycles, write 2 more (0xA3, 0xA4).
  - Required: a single word 0xA4A3A2A1 with WORD_BYTES=4; no partial word is emitted.
- Flush disabled:
  - Stimulus: FLUSH_TIMEOUT=0; write 3 bytes; idle for 200 cycles.
  - Required: WORD_VALID stays 0 and acc_cnt stays 3.
- Reset mid-word:
  - Stimulus: write 6 bytes; assert RST=0 for one edge after the 5th capture; then write 4 more bytes.
  - Required: outputs read zero immediately after the reset edge; WORD_COUNT=0; the next word contains only post-reset bytes.
- Empty guard and counter wrap:
  - Stimulus: preload WORD_COUNT to 0xFFFF via force; toggle EMPTY randomly.
  - Required: READ_ENABLE is never high while EMPTY=1.
  - The next acceptance gives WORD_COUNT=0x0000.
